// File: rtl/serv_mtimer_pkg.sv
// Shared register map, reset constants and byte-lane helper for the machine timer.
package serv_mtimer_pkg;

    localparam logic [2:0] MTIME_LO = 3'd0;
    localparam logic [2:0] MTIME_HI = 3'd1;
    localparam logic [2:0] CMP_LO   = 3'd2;
    localparam logic [2:0] CMP_HI   = 3'd3;
    localparam logic [2:0] CTRL     = 3'd4;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PRE_LSB = 8;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// Prescaler: counts 0..pre while enabled and emits a tick on the wrap cycle.
module serv_mtimer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [PRE_W-1:0] i_pre,
    output logic             o_tick
);

    logic [PRE_W-1:0] cnt;

    // >= rather than == so a reload lowered below the running count still wraps
    assign o_tick = i_en & (cnt >= i_pre);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            if (cnt >= i_pre) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a 32-bit Wishbone slave, level mtip output.
module serv_mtimer
    import serv_mtimer_pkg::*;
#(
    parameter int PRE_W     = 8,
    parameter int RESET_PRE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [31:0]      hi_shadow;
    logic             en;
    logic [PRE_W-1:0] pre;
    logic             tick;

    logic             req;
    logic             wr;
    logic             rd;
    logic [31:0]      rd_data;
    logic             en_next;
    logic [PRE_W-1:0] pre_next;

    // A request is taken only while ack is low, so a held cycle is acked every other clock
    assign req = i_wb_cyc & ~o_wb_ack;
    assign wr  = req & i_wb_we;
    assign rd  = req & ~i_wb_we;

    serv_mtimer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_clr   (wr && (i_wb_adr == CTRL)),
        .i_pre   (pre),
        .o_tick  (tick)
    );

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            MTIME_LO: rd_data = mtime[31:0];
            MTIME_HI: rd_data = hi_shadow;
            CMP_LO:   rd_data = mtimecmp[31:0];
            CMP_HI:   rd_data = mtimecmp[63:32];
            CTRL: begin
                rd_data[CTRL_EN_BIT]              = en;
                rd_data[CTRL_PRE_LSB +: PRE_W]    = pre;
            end
            default:  rd_data = '0;
        endcase
    end

    always_comb begin
        en_next  = i_wb_sel[CTRL_EN_BIT / 8] ? i_wb_dat[CTRL_EN_BIT] : en;
        pre_next = pre;
        for (int b = 0; b < PRE_W; b++) begin
            if (i_wb_sel[(CTRL_PRE_LSB + b) / 8]) begin
                pre_next[b] = i_wb_dat[CTRL_PRE_LSB + b];
            end
        end
    end

    // A bus write to either half wins over the tick; the other half is left alone
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime <= '0;
        end else if (wr && (i_wb_adr == MTIME_LO)) begin
            mtime[31:0] <= byte_merge(mtime[31:0], i_wb_dat, i_wb_sel);
        end else if (wr && (i_wb_adr == MTIME_HI)) begin
            mtime[63:32] <= byte_merge(mtime[63:32], i_wb_dat, i_wb_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_shadow <= '0;
        end else if (wr && (i_wb_adr == MTIME_HI)) begin
            hi_shadow <= byte_merge(mtime[63:32], i_wb_dat, i_wb_sel);
        end else if (rd && (i_wb_adr == MTIME_LO)) begin
            hi_shadow <= mtime[63:32];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= CMP_RESET;
            en       <= 1'b1;
            pre      <= PRE_W'(RESET_PRE);
        end else if (wr) begin
            case (i_wb_adr)
                CMP_LO:  mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
                CMP_HI:  mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
                CTRL: begin
                    en  <= en_next;
                    pre <= pre_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            o_irq    <= 1'b0;
        end else begin
            o_wb_ack <= req;
            o_wb_rdt <= rd ? rd_data : 32'd0;
            o_irq    <= (mtime >= mtimecmp);
        end
    end

endmodule
